// File: rtl/gem_gtx_optical_tx.sv
// GEM fiber-link TX framer: one 56-bit payload per BX is sent as four 16-bit 8b/10b words.
// A K-char marker in word0 flags start, data or FC frames; PRBS-15 can replace the payload.
module gem_gtx_optical_tx #(
  parameter int unsigned START_BX  = 16,
  parameter logic [55:0] START_PAT = 56'hF7F7F7F7F7F7F7,
  parameter logic [15:0] IDLE_WORD = 16'h50BC
) (
  input  logic        clock_160,
  input  logic        reset,
  input  logic        bx_strobe,
  input  logic        tx_enable,
  input  logic [55:0] tx_data,
  input  logic        en_prbs_test,
  input  logic        send_fc,
  input  logic        inject_err,
  output logic [15:0] txdata,
  output logic [1:0]  txcharisk,
  output logic        tx_ready,
  output logic        fc_sent,
  output logic        phase_err,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN} state_t;

  localparam int unsigned CW   = $clog2(START_BX + 1);
  localparam logic [7:0]  K285 = 8'hBC;
  localparam logic [7:0]  K281 = 8'h3C;
  localparam logic [7:0]  K287 = 8'hFC;

  state_t        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [55:0]   pay_q, pay_d;
  logic [14:0]   lfsr_q, lfsr_d;
  logic          fc_pend_q, fc_pend_d;
  logic          err_pend_q, err_pend_d;
  logic [15:0]   txdata_q, txdata_d;
  logic [1:0]    charisk_q, charisk_d;
  logic          ready_q;
  logic          fc_sent_q, fc_sent_d;
  logic          perr_q;
  logic [15:0]   fcnt_q, fcnt_d;

  logic          misalign;
  logic          boundary;
  logic          flip;
  logic [7:0]    marker;
  logic [55:0]   prbs;
  logic [14:0]   lfsr_adv;

  always_comb begin
    misalign = bx_strobe && (phase_q != 2'd3);
    phase_d  = misalign ? 2'd0 : phase_q + 2'd1;
    boundary = (phase_d == 2'd0);

    // 56 serial LFSR steps per frame; the first generated bit lands in pay[55].
    lfsr_adv = lfsr_q;
    prbs     = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      prbs     = {prbs[54:0], lfsr_adv[14] ^ lfsr_adv[13]};
      lfsr_adv = {lfsr_adv[13:0], lfsr_adv[14] ^ lfsr_adv[13]};
    end

    state_d    = state_q;
    cnt_d      = cnt_q;
    pay_d      = pay_q;
    lfsr_d     = lfsr_q;
    fc_pend_d  = fc_pend_q | send_fc;
    err_pend_d = err_pend_q | inject_err;
    fc_sent_d  = 1'b0;
    fcnt_d     = fcnt_q;
    txdata_d   = IDLE_WORD;
    charisk_d  = 2'b01;
    flip       = 1'b0;
    marker     = K285;

    // The state only changes where a new frame begins, so state_q names the frame on the wire.
    if (boundary) begin
      if (!tx_enable) begin
        state_d = ST_IDLE;
      end else if (misalign) begin
        if (state_q != ST_IDLE) begin
          state_d = ST_START;
          cnt_d   = CW'(1);
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bx_strobe) begin
              state_d = ST_START;
              cnt_d   = CW'(1);
            end
          end
          ST_START: begin
            if (cnt_q == CW'(START_BX)) state_d = ST_RUN;
            else                        cnt_d   = cnt_q + CW'(1);
          end
          default: state_d = ST_RUN;
        endcase
      end

      case (state_d)
        ST_START: begin
          pay_d  = START_PAT;
          lfsr_d = '1;
        end
        ST_RUN: begin
          if (bx_strobe) begin
            if (en_prbs_test) begin
              pay_d  = prbs;
              lfsr_d = lfsr_adv;
            end else begin
              pay_d = tx_data;
            end
          end
          fcnt_d = fcnt_q + 16'd1;
          if (fc_pend_q) begin
            fc_sent_d = 1'b1;
            fc_pend_d = send_fc;
          end
        end
        default: ;
      endcase
    end

    if (state_d == ST_START)  marker = K281;
    else if (fc_sent_d)       marker = K287;

    if ((state_d == ST_RUN) && (phase_d == 2'd1) && err_pend_q) begin
      flip       = 1'b1;
      err_pend_d = inject_err;
    end

    if (state_d != ST_IDLE) begin
      case (phase_d)
        2'd0: begin
          txdata_d  = {pay_d[55:48], marker};
          charisk_d = 2'b01;
        end
        2'd1: begin
          txdata_d  = pay_q[47:32] ^ {15'd0, flip};
          charisk_d = 2'b00;
        end
        2'd2: begin
          txdata_d  = pay_q[31:16];
          charisk_d = 2'b00;
        end
        default: begin
          txdata_d  = pay_q[15:0];
          charisk_d = 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge clock_160) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= 2'd3;
      cnt_q      <= '0;
      pay_q      <= '0;
      lfsr_q     <= '1;
      fc_pend_q  <= 1'b0;
      err_pend_q <= 1'b0;
      txdata_q   <= IDLE_WORD;
      charisk_q  <= 2'b01;
      ready_q    <= 1'b0;
      fc_sent_q  <= 1'b0;
      perr_q     <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      pay_q      <= pay_d;
      lfsr_q     <= lfsr_d;
      fc_pend_q  <= fc_pend_d;
      err_pend_q <= err_pend_d;
      txdata_q   <= txdata_d;
      charisk_q  <= charisk_d;
      ready_q    <= (state_d == ST_RUN);
      fc_sent_q  <= fc_sent_d;
      perr_q     <= misalign;
      fcnt_q     <= fcnt_d;
    end
  end

  assign txdata      = txdata_q;
  assign txcharisk   = charisk_q;
  assign tx_ready    = ready_q;
  assign fc_sent     = fc_sent_q;
  assign phase_err   = perr_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_gem_gtx_optical_tx.sv
// Directed bench for gem_gtx_optical_tx: bring-up, data mapping, FC, realignment, PRBS/error, disable, reset.
module tb_gem_gtx_optical_tx;

  localparam logic [55:0] START_PAT = 56'hF7F7F7F7F7F7F7;

  logic        clock_160 = 1'b0;
  logic        reset;
  logic        bx_strobe;
  logic        tx_enable;
  logic [55:0] tx_data;
  logic        en_prbs_test;
  logic        send_fc;
  logic        inject_err;
  logic [15:0] txdata;
  logic [1:0]  txcharisk;
  logic        tx_ready;
  logic        fc_sent;
  logic        phase_err;
  logic [15:0] frame_count;

  int tests = 0;
  int fails = 0;

  logic [15:0] wd [4];
  logic [1:0]  ck [4];
  logic        rdy0;
  logic [15:0] fcnt0;
  int          fcs;
  int          pe;
  logic        refb [0:299];
  logic [55:0] mp;

  gem_gtx_optical_tx #(
    .START_BX (16),
    .START_PAT(START_PAT),
    .IDLE_WORD(16'h50BC)
  ) dut (
    .clock_160   (clock_160),
    .reset       (reset),
    .bx_strobe   (bx_strobe),
    .tx_enable   (tx_enable),
    .tx_data     (tx_data),
    .en_prbs_test(en_prbs_test),
    .send_fc     (send_fc),
    .inject_err  (inject_err),
    .txdata      (txdata),
    .txcharisk   (txcharisk),
    .tx_ready    (tx_ready),
    .fc_sent     (fc_sent),
    .phase_err   (phase_err),
    .frame_count (frame_count)
  );

  always #5 clock_160 = ~clock_160;

  task automatic step;
    @(posedge clock_160);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One BX: strobe on the first cycle; masks choose on which of the 4 cycles to pulse inputs.
  task automatic frame(input logic [55:0] d, input logic [3:0] fc_m,
                       input logic [3:0] err_m, input logic [3:0] dis_m);
    fcs = 0;
    pe  = 0;
    for (int c = 0; c < 4; c++) begin
      bx_strobe = (c == 0);
      if (c == 0) tx_data = d;
      send_fc    = fc_m[c];
      inject_err = err_m[c];
      if (dis_m[c]) tx_enable = 1'b0;
      step;
      wd[c] = txdata;
      ck[c] = txcharisk;
      if (c == 0) begin
        rdy0  = tx_ready;
        fcnt0 = frame_count;
      end
      fcs += int'(fc_sent);
      pe  += int'(phase_err);
    end
    bx_strobe  = 1'b0;
    send_fc    = 1'b0;
    inject_err = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic [55:0] p, input logic [7:0] mk);
    chk($sformatf("%s w0", tag), 64'(wd[0]), 64'({p[55:48], mk}));
    chk($sformatf("%s w1", tag), 64'(wd[1]), 64'(p[47:32]));
    chk($sformatf("%s w2", tag), 64'(wd[2]), 64'(p[31:16]));
    chk($sformatf("%s w3", tag), 64'(wd[3]), 64'(p[15:0]));
    chk($sformatf("%s k", tag), 64'({ck[0], ck[1], ck[2], ck[3]}), 64'h40);
  endtask

  // Reference PRBS-15 (x^15+x^14+1) from recurrence b[n] = b[n-15] ^ b[n-14], seed all ones.
  function automatic logic [55:0] ref_pay(input int unsigned k);
    logic [55:0] p;
    p = '0;
    for (int unsigned j = 0; j < 56; j++) p = {p[54:0], refb[15 + 56 * k + j]};
    return p;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 15; i++) refb[i] = 1'b1;
    for (int i = 15; i < 300; i++) refb[i] = refb[i-15] ^ refb[i-14];

    reset = 1'b1; bx_strobe = 1'b0; tx_enable = 1'b0; tx_data = '0;
    en_prbs_test = 1'b0; send_fc = 1'b0; inject_err = 1'b0;
    step;
    step;
    chk("rst txdata", 64'(txdata), 64'h50BC);
    chk("rst charisk", 64'(txcharisk), 64'h1);
    chk("rst ready", 64'(tx_ready), 64'h0);
    chk("rst fc_sent", 64'(fc_sent), 64'h0);
    chk("rst phase_err", 64'(phase_err), 64'h0);
    chk("rst frame_count", 64'(frame_count), 64'h0);

    // Bring-up: phase is 3 right after reset, so strobe immediately.
    reset = 1'b0;
    tx_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      frame(56'h0, 4'b0, 4'b0, 4'b0);
      chk_frame($sformatf("start%0d", i), START_PAT, 8'h3C);
      chk("start ready", 64'(rdy0), 64'h0);
    end

    frame(56'h0123456789ABCD, 4'b0, 4'b0, 4'b0);
    chk_frame("data1", 56'h0123456789ABCD, 8'hBC);
    chk("data1 ready", 64'(rdy0), 64'h1);
    chk("data1 fcnt", 64'(fcnt0), 64'd1);
    frame(56'hFEDCBA98765432, 4'b0, 4'b0, 4'b0);
    chk_frame("data2", 56'hFEDCBA98765432, 8'hBC);
    chk("data2 fcnt", 64'(fcnt0), 64'd2);

    // FC: two requests in one BX merge into one marker on the next frame.
    frame(56'h11223344556677, 4'b0110, 4'b0, 4'b0);
    chk_frame("fcA", 56'h11223344556677, 8'hBC);
    chk("fcA sent", 64'(fcs), 64'd0);
    frame(56'h8899AABBCCDDEE, 4'b0, 4'b0, 4'b0);
    chk_frame("fcB", 56'h8899AABBCCDDEE, 8'hFC);
    chk("fcB sent", 64'(fcs), 64'd1);
    // Request on the strobe cycle itself is served one frame later.
    frame(56'h13579BDF02468A, 4'b0001, 4'b0, 4'b0);
    chk_frame("fcC", 56'h13579BDF02468A, 8'hBC);
    chk("fcC sent", 64'(fcs), 64'd0);
    frame(56'h2468ACE13579BD, 4'b0, 4'b0, 4'b0);
    chk_frame("fcD", 56'h2468ACE13579BD, 8'hFC);
    chk("fcD sent", 64'(fcs), 64'd1);
    frame(56'h0F0F0F0F0F0F0F, 4'b0, 4'b0, 4'b0);
    chk_frame("fcE", 56'h0F0F0F0F0F0F0F, 8'hBC);
    chk("fcE sent", 64'(fcs), 64'd0);
    chk("fcE fcnt", 64'(fcnt0), 64'd7);

    // Misalignment: start a frame, then strobe at phase 1.
    bx_strobe = 1'b1;
    tx_data = 56'h55AA55AA55AA55;
    step;
    chk("part w0", 64'(txdata), 64'h55BC);
    bx_strobe = 1'b0;
    step;
    chk("part w1", 64'(txdata), 64'hAA55);
    en_prbs_test = 1'b1;
    frame(56'h0, 4'b0, 4'b0, 4'b0);
    chk("mis phase_err", 64'(pe), 64'd1);
    chk("mis ready", 64'(rdy0), 64'h0);
    chk_frame("restart0", START_PAT, 8'h3C);
    for (int i = 1; i < 16; i++) begin
      frame(56'h0, (i == 4) ? 4'b0100 : 4'b0000, 4'b0, 4'b0);
      chk_frame($sformatf("restart%0d", i), START_PAT, 8'h3C);
      chk("restart phase_err", 64'(pe), 64'd0);
      chk("restart ready", 64'(rdy0), 64'h0);
      chk("restart fc_sent", 64'(fcs), 64'd0);
    end

    // First RUN frame: hand-computed first 56 PRBS bits, FC held over from START.
    frame(56'hDEADBEEFDEADBE, 4'b0, 4'b0100, 4'b0);
    chk_frame("prbs0", 56'h0002000C002800, 8'hFC);
    chk("prbs0 fc_sent", 64'(fcs), 64'd1);
    chk("prbs0 ready", 64'(rdy0), 64'h1);
    chk("prbs0 fcnt", 64'(fcnt0), 64'd9);
    frame(56'hDEADBEEFDEADBE, 4'b0, 4'b0, 4'b0);
    mp = ref_pay(1);
    chk("prbs1 w0", 64'(wd[0]), 64'({mp[55:48], 8'hBC}));
    chk("prbs1 w1 flipped", 64'(wd[1]), 64'(mp[47:32] ^ 16'h0001));
    chk("prbs1 w2", 64'(wd[2]), 64'(mp[31:16]));
    chk("prbs1 w3", 64'(wd[3]), 64'(mp[15:0]));
    frame(56'hDEADBEEFDEADBE, 4'b0, 4'b0, 4'b0);
    chk_frame("prbs2", ref_pay(2), 8'hBC);
    chk("prbs2 fcnt", 64'(fcnt0), 64'd11);

    // Disable mid-frame: frame completes, then idle.
    en_prbs_test = 1'b0;
    frame(56'hCAFEF00DBEEF12, 4'b0, 4'b0, 4'b0010);
    chk_frame("dis", 56'hCAFEF00DBEEF12, 8'hBC);
    chk("dis fcnt", 64'(fcnt0), 64'd12);
    frame(56'h0, 4'b0, 4'b0, 4'b0);
    chk("idle words", 64'({wd[0], wd[1], wd[2], wd[3]}), 64'h50BC50BC50BC50BC);
    chk("idle k", 64'({ck[0], ck[1], ck[2], ck[3]}), 64'h55);
    chk("idle ready", 64'(rdy0), 64'h0);
    chk("idle fcnt", 64'(fcnt0), 64'd12);

    // Re-enable, then reset in the middle of a start frame.
    tx_enable = 1'b1;
    frame(56'h0, 4'b0, 4'b0, 4'b0);
    chk("reen w0", 64'(wd[0]), 64'hF73C);
    bx_strobe = 1'b1;
    step;
    bx_strobe = 1'b0;
    step;
    chk("pre-rst w1", 64'(txdata), 64'hF7F7);
    reset = 1'b1;
    step;
    chk("midrst txdata", 64'(txdata), 64'h50BC);
    chk("midrst charisk", 64'(txcharisk), 64'h1);
    chk("midrst fcnt", 64'(frame_count), 64'h0);
    chk("midrst ready", 64'(tx_ready), 64'h0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gem_gtx_optical_tx.md
Name: gem_gtx_optical_tx

Overview:
- Transmit-side framer for the GEM fiber link: serialises one 56-bit GEM cluster word per bunch crossing (BX) into four 16-bit 8b/10b GTX TX words at 160 MHz.
- Emits the frame markers, start pattern, "FC" latency code and PRBS test payload that the GEM GTX receiver expects.
- Sits between GEM cluster/test logic and the GTX TX user interface (TXDATA/TXCHARISK) in the test-stand and loopback path.

Parameters:
- START_BX, 16, number of start-pattern frames sent after enable or realign before data frames.
- START_PAT, 56'hF7F7F7F7F7F7F7, payload of start-pattern frames.
- IDLE_WORD, 16'h50BC, idle word; low byte is K28.5.

Ports:
- clock_160  in  1  160 MHz GTX TX user clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- bx_strobe  in  1  one-cycle pulse, once per 4 clocks, marking the BX boundary; tx_data is sampled on this cycle.
- tx_enable  in  1  link enable; 0 forces idle.
- tx_data  in  56  GEM payload for the current BX.
- en_prbs_test  in  1  replace payload with PRBS-15.
- send_fc  in  1  request an FC latency marker.
- inject_err  in  1  flip one payload bit (test).
- txdata  out  16  GTX TXDATA.
- txcharisk  out  2  GTX TXCHARISK.
- tx_ready  out  1  high while in RUN.
- fc_sent  out  1  one-cycle pulse when an FC marker word is driven.
- phase_err  out  1  one-cycle pulse on a misaligned bx_strobe.
- frame_count  out  16  data frames sent, wrapping.

Behaviour:
- Reset values:
  - txdata = IDLE_WORD, txcharisk = 2'b01.
  - tx_ready, fc_sent and phase_err = 0; frame_count = 0.
  - State = IDLE, phase = 3, pending FC/err flags cleared, LFSR = 15'h7FFF.
- Phase counter:
  - 2-bit, increments mod 4 every clock.
  - bx_strobe while phase==3 is aligned; phase becomes 0 next cycle.
  - bx_strobe while phase!=3: phase_err pulses 1 cycle later, phase is forced to 0, and any non-IDLE state goes to START with the start counter cleared.
- Word slots:
  - tx_data is captured on the bx_strobe cycle t.
  - word0 is driven at t+1, word1 at t+2, word2 at t+3, word3 at t+4. Latency = 1 clock, all outputs registered.
- Frame layout:
  - word0 = {pay[55:48], marker}, txcharisk = 01.
  - word1 = pay[47:32], word2 = pay[31:16], word3 = pay[15:0]; txcharisk = 00.
  - Marker is 8'hBC (K28.5) for data frames, 8'h3C (K28.1) for start frames, 8'hFC (K28.7) for an FC frame.
- States:
  - IDLE: all words are IDLE_WORD with txcharisk = 01. Leave for START on the first aligned bx_strobe with tx_enable=1.
  - START: send START_BX start frames (pay = START_PAT, marker 3C), counted on word0, then go to RUN at the next frame boundary.
  - RUN: data frames; tx_ready = 1. frame_count increments on each word0.
  - tx_enable=0 in any state returns to IDLE at the next frame boundary (after word3). Only reset aborts mid-frame.
- Payload:
  - pay = captured tx_data when en_prbs_test=0.
  - When en_prbs_test=1, pay comes from PRBS-15 (x^15+x^14+1), advancing 56 bits per frame, MSB first.
  - en_prbs_test is sampled only at bx_strobe.
  - The LFSR holds when en_prbs_test=0. It reseeds to 7FFF on entry to START.
- FC:
  - A send_fc pulse sets fc_pending.
  - The next RUN-state word0 uses marker FC instead of BC and pulses fc_sent, then clears fc_pending.
  - Multiple requests before service merge into one. Requests in IDLE/START stay pending until RUN.
  - A request arriving in the same cycle as word0 is served at the next frame.
- inject_err:
  - Sets err_pending.
  - The next RUN word1 is driven with bit 0 inverted, then err_pending clears. Merging rules are the same as FC.
- frame_count wraps FFFF→0000. It is cleared only by reset.
- reset mid-frame: outputs return to IDLE_WORD on the next clock. No partial frame completes.

Test Plan:
- Bring-up: reset, tx_enable=1, aligned bx_strobe every 4 clocks, START_BX=16.
  - Required: 16 frames of word0 = F73C / txcharisk 01 and word1..3 = F7F7, then RUN.
  - tx_ready rises on the first data word0.
- Data mapping: in RUN, tx_data = 56'h0123456789ABCD.
  - Required: words 01BC, 2345, 6789, ABCD with txcharisk 01, 00, 00, 00.
  - word0 one clock after the strobe; frame_count increments by 1.
- FC: pulse send_fc twice within one BX in RUN.
  - Required: exactly one word0 = {pay[55:48], FC} and one fc_sent pulse; the following frame uses BC.
- Misalignment: in RUN, issue bx_strobe at phase 1.
  - Required: phase_err pulses once, tx_ready falls, 16 start frames, then RUN again with the new alignment.
- PRBS and error injection: en_prbs_test=1.
  - Required: the payload matches a reference PRBS-15 seeded 7FFF from the first start-exit frame.
  - One inject_err flips bit 0 of exactly one word1.
- Disable and reset: deassert tx_enable mid-frame.
  - Required: the current frame completes, then IDLE_WORD follows.
  - Assert reset mid-frame: 50BC on the next clock; frame_count = 0.
